// File: rtl/deparse_field_merger.sv
// deparse_field_merger: sequences up to C_NUM_ACTS deparse actions into one
// sub-deparser lane and merges the returned field values into the header
// buffer at each action's byte offset, then hands the header downstream.

// One header byte: picks its new value from the returned field when the
// write window [off, off+len) covers this byte. The field is big-endian.
module dfm_byte_lane #(
  parameter int LANE = 0
) (
  input  logic        en,
  input  logic [6:0]  off,
  input  logic [2:0]  len,
  input  logic [47:0] val,
  input  logic [7:0]  cur,
  output logic [7:0]  nxt
);
  localparam logic [7:0] LANE_B = 8'(LANE);

  logic [7:0] rel;
  logic [2:0] pos;
  logic       hit;

  // Window test and big-endian byte pick. Lanes past the window (including
  // anything that would run off the end of the header) keep their value.
  always_comb begin
    rel = LANE_B - {1'b0, off};
    hit = en && (LANE_B >= {1'b0, off}) && (rel < {5'b0, len});
    pos = len - 3'd1 - rel[2:0];
    nxt = hit ? val[{pos, 3'b000} +: 8] : cur;
  end
endmodule

module deparse_field_merger #(
  parameter int C_PKT_VEC_WIDTH = 1024,
  parameter int C_HDR_WIDTH     = 1024,
  parameter int C_PARSE_ACT_LEN = 16,
  parameter int C_NUM_ACTS      = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 hdr_in_valid,
  output logic                                 hdr_in_ready,
  input  logic [C_HDR_WIDTH-1:0]               hdr_in,
  input  logic [C_PKT_VEC_WIDTH-1:0]           phv_in,
  input  logic [C_NUM_ACTS*C_PARSE_ACT_LEN-1:0] acts_in,
  output logic                                 sub_act_valid,
  output logic [5:0]                           sub_act,
  output logic [C_PKT_VEC_WIDTH-1:0]           sub_phv,
  input  logic                                 val_in_valid,
  input  logic [47:0]                          val_in,
  input  logic [1:0]                           val_in_type,
  output logic                                 hdr_out_valid,
  output logic [C_HDR_WIDTH-1:0]               hdr_out,
  input  logic                                 hdr_out_ready
);
  localparam int HDR_BYTES = C_HDR_WIDTH / 8;
  localparam int IW = (C_NUM_ACTS > 1) ? $clog2(C_NUM_ACTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(C_NUM_ACTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t                                      state_q, state_d;
  logic [C_NUM_ACTS-1:0][C_PARSE_ACT_LEN-1:0]  acts_q;
  logic [C_PARSE_ACT_LEN-1:0]                  cur_act;
  logic [IW-1:0]                               idx_q;
  logic [6:0]                                  off_q;
  logic [C_HDR_WIDTH-1:0]                      hdr_q, hdr_mrg;
  logic [2:0]                                  wr_len;
  logic                                        merge_en;
  logic                                        unused_act_hi;

  assign cur_act       = acts_q[idx_q];
  assign unused_act_hi = ^cur_act[C_PARSE_ACT_LEN-1:13];
  assign hdr_out       = hdr_q;

  // A return is only meaningful while an action is in flight: from the
  // second issue cycle through the drain cycle. Type 00 carries no write.
  assign wr_len   = {val_in_type, 1'b0};
  assign merge_en = val_in_valid && (val_in_type != 2'b00) &&
                    (((state_q == S_ISSUE) && (idx_q != '0)) || (state_q == S_DRAIN));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/issue outputs.
  always_comb begin
    state_d       = state_q;
    hdr_in_ready  = 1'b0;
    hdr_out_valid = 1'b0;
    sub_act_valid = 1'b0;
    sub_act       = '0;
    case (state_q)
      S_IDLE: begin
        hdr_in_ready = 1'b1;
        if (hdr_in_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        sub_act       = cur_act[5:0];
        sub_act_valid = cur_act[0];
        if (idx_q == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        hdr_out_valid = 1'b1;
        if (hdr_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture a packet, step the action index, and delay each offset by one
  // cycle so it lines up with the sub-deparser's returned value.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q   <= '0;
      sub_phv <= '0;
      acts_q  <= '0;
      idx_q   <= '0;
      off_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hdr_in_valid) begin
            hdr_q   <= hdr_in;
            sub_phv <= phv_in;
            acts_q  <= acts_in;
            idx_q   <= '0;
          end
        end
        S_ISSUE: begin
          hdr_q <= hdr_mrg;
          off_q <= cur_act[12:6];
          idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
        S_DRAIN: hdr_q <= hdr_mrg;
        default: ;
      endcase
    end
  end

  for (genvar b = 0; b < HDR_BYTES; b++) begin : g_lane
    dfm_byte_lane #(.LANE(b)) u_lane (
      .en  (merge_en),
      .off (off_q),
      .len (wr_len),
      .val (val_in),
      .cur (hdr_q[8*b +: 8]),
      .nxt (hdr_mrg[8*b +: 8])
    );
  end
endmodule
